// File: rtl/div_iter_unit.sv
// Iterative RV32M divide/remainder unit: radix-2 restoring, one quotient bit per cycle.
// Divide-by-zero and signed overflow complete at accept without entering CALC.
module div_iter_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      div_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] dvd, dvs, rem, quo;
  logic            want_q, sign_q, sign_r;

  logic            s1, s2, accept;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   sh, diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix;

  assign in_ready = (state == IDLE);
  assign busy     = (state == CALC) || (state == DONE);
  assign accept   = in_valid && in_ready && (div_op[2] || div_op[1]) && !flush;

  always_comb begin
    s1   = div_op[0] & src1[XLEN-1];
    s2   = div_op[0] & src2[XLEN-1];
    abs1 = s1 ? (XLEN'(0) - src1) : src1;
    abs2 = s2 ? (XLEN'(0) - src2) : src2;
    // Partial remainder stays below the divisor, so one extra bit holds the shifted value.
    sh     = {rem, dvd[XLEN-1]};
    ge     = (sh >= {1'b0, dvs});
    diff   = sh - {1'b0, dvs};
    rem_nx = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
    quo_nx = {quo[XLEN-2:0], ge};
    q_fix  = sign_q ? (XLEN'(0) - quo_nx) : quo_nx;
    r_fix  = sign_r ? (XLEN'(0) - rem_nx) : rem_nx;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      quo       <= '0;
      want_q    <= 1'b0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          want_q <= div_op[2];
          sign_q <= s1 ^ s2;
          sign_r <= s1;
          dvd    <= abs1;
          dvs    <= abs2;
          rem    <= '0;
          quo    <= '0;
          cnt    <= '0;
          if (src2 == '0) begin
            result    <= div_op[2] ? '1 : src1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (div_op[0] && src1 == INT_MIN && src2 == '1) begin
            result    <= div_op[2] ? INT_MIN : '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          dvd <= {dvd[XLEN-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN-1)) begin
            result    <= want_q ? q_fix : r_fix;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: expected results queued at issue, compared on handshake.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, out_ready;
  logic [2:0]  div_op;
  logic [31:0] src1, src2;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  div_iter_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .div_op(div_op),
    .src1(src1), .src2(src2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge, away from both edges.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model for random operands (SV signed division truncates toward zero).
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[2] ? 32'hFFFF_FFFF : a;
    if (op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[2] ? 32'h8000_0000 : 32'h0;
      return op[2] ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
    end
    return op[2] ? a / b : a % b;
  endfunction

  // Handshake monitor: pop and compare when the result is consumed.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else chk("result", result, sb.pop_front());
    end
  end

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat, input int bp);
    int n;
    logic rdy_seen;
    logic [31:0] held;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; div_op = op; src1 = a; src2 = b;
    sb.push_back(exp);
    step();
    in_valid = 1'b0;
    n = 1;
    rdy_seen = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      step();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_busy_rdy"}, 32'(rdy_seen), 32'd0);
    held = result;
    repeat (bp) begin
      step();
      chk({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_bp_hold"}, result, held);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    div_op = 3'b000; src1 = '0; src2 = '0;
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    resetn = 1'b1;
    step();

    run_op("divu", 3'b100, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op("remu", 3'b010, 32'd100, 32'd7, 32'd2, 33, 0);
    run_op("div_neg", 3'b101, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_neg", 3'b011, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op("rem_negdvs", 3'b011, 32'd7, -32'sd2, 32'd1, 33, 0);
    run_op("div_negdvs", 3'b101, 32'd7, -32'sd2, 32'hFFFF_FFFD, 33, 0);
    run_op("divu_max", 3'b100, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33, 0);
    run_op("div_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_by0", 3'b011, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op("divu_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("div_ovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_op("bp_divu", 3'b100, 32'd1000, 32'd10, 32'd100, 33, 5);

    // Flush during CALC: accept at T, flush edge ends T+10.
    in_valid = 1'b1; div_op = 3'b100; src1 = 32'd12345; src2 = 32'd17;
    step();
    in_valid = 1'b0;
    n = 0;
    repeat (9) begin
      if (out_valid) n++;
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid + n), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    run_op("after_flush", 3'b100, 32'd9, 32'd3, 32'd3, 33, 0);

    // Flush together with out_ready in DONE: no handshake, back to IDLE.
    in_valid = 1'b1; div_op = 3'b101; src1 = 32'd5; src2 = 32'd0;
    step();
    in_valid = 1'b0;
    chk("fo_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; flush = 1'b1;
    step();
    out_ready = 1'b0; flush = 1'b0;
    chk("fo_idle_valid", 32'(out_valid), 32'd0);
    chk("fo_idle_ready", 32'(in_ready), 32'd1);
    chk("fo_sb", 32'(sb.size()), 32'd0);

    // Reset mid-CALC.
    in_valid = 1'b1; div_op = 3'b100; src1 = 32'd777; src2 = 32'd5;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("mid_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);

    // div_op=000 is ignored.
    in_valid = 1'b1; div_op = 3'b000; src1 = 32'd8; src2 = 32'd2;
    step();
    in_valid = 1'b0;
    chk("nop_ready", 32'(in_ready), 32'd1);
    chk("nop_busy", 32'(busy), 32'd0);
    step();
    chk("nop_valid", 32'(out_valid), 32'd0);

    // Random operands against the reference model.
    for (int i = 0; i < 6; i++) begin
      rop = (i % 2 == 0) ? 3'b100 : 3'b010;
      rop[0] = (i >= 2);
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 0) rb = 32'd3;
      run_op("rand", rop, ra, rb, ref_div(rop, ra, rb), 33, i % 3);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Iterative 32-bit RV32M divide/remainder unit in the EX stage, downstream of the instruction decoder.
- Consumes the decoder's 3-bit div_op plus the two register-file operands.
- Produces one result per accepted operation using a radix-2 restoring algorithm (one quotient bit per cycle).
- Uses a valid/ready handshake on both sides so the pipeline can stall on it and flush it.

Parameters:
XLEN, 32, operand/result width; the only supported value is 32.
CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
flush  input  1  pipeline flush; kills any in-flight operation
in_valid  input  1  operation presented
in_ready  output  1  unit can accept (high only in IDLE)
div_op  input  3  {div, rem, signed_div} from decoder: [2]=quotient wanted, [1]=remainder wanted, [0]=signed
src1  input  32  dividend (rs1)
src2  input  32  divisor (rs2)
out_valid  output  1  result available, held until consumed
out_ready  input  1  consumer takes result
result  output  32  quotient or remainder
busy  output  1  high in CALC or DONE

Behaviour:
- Reset: while resetn=0 at a clk edge:
  - state -> IDLE
  - out_valid=0, result=0, busy=0, counter=0, internal regs cleared
  - in_ready=1 from the first cycle after reset
- States:
  - IDLE: in_ready=1.
  - CALC: 32 iteration cycles.
  - DONE: out_valid=1 and result stable.
- Accept (IDLE), when in_valid & in_ready & (div_op[2]|div_op[1]) & ~flush:
  - Latch op and operands.
  - in_valid with div_op[2:1]=00 is ignored and the unit stays in IDLE.
  - If both div_op[2] and div_op[1] are set, quotient wins (decoder never does this).
- Special cases at accept; state goes straight to DONE:
  - Divisor==0: quotient=0xFFFFFFFF, remainder=src1 (signed and unsigned).
  - Signed with src1=0x80000000, src2=0xFFFFFFFF: quotient=0x80000000, remainder=0.
  - Latency: accept at cycle T, out_valid high from T+1.
- Normal path:
  - Signed: operate on |src1|, |src2|; record sign_q = s1^s2 and sign_r = s1.
  - CALC cycle k (k=0..31): rem = {rem[30:0], dvd[31-k]} - divisor if no borrow, quotient bit = 1; otherwise shift only, quotient bit = 0.
  - Counter increments each CALC cycle; after the cycle with counter==31, go to DONE.
  - In DONE, the final result is registered with sign correction applied:
    - quotient negated if sign_q
    - remainder negated if sign_r
    - unsigned: no correction
  - Latency: accept at T, CALC cycles T+1..T+32, out_valid high from T+33.
- DONE:
  - out_valid=1; result constant while out_ready=0 (arbitrary backpressure).
  - On out_ready=1: go to IDLE next cycle, out_valid=0 next cycle, in_ready=1 next cycle.
  - No accept in the same cycle as consumption.
- Flush:
  - Any state -> IDLE next cycle; out_valid=0 next cycle; result discarded.
  - Flush beats out_ready and beats a new accept in the same cycle.
- busy=1 exactly when state is CALC or DONE.
- Result width is always 32 bits; all negation is two's complement mod 2^32.

Test Plan:
- divu 100/7 (div_op=100) -> out_valid at T+33, result=14; remu (010) -> 2. Check in_ready=0 for T+1..T+33.
- div -7/2 (101) -> 0xFFFFFFFD; rem (011) -> 0xFFFFFFFF; rem 7/-2 -> 1; divu 0xFFFFFFFF/2 -> 0x7FFFFFFF.
- Divide by zero:
  - div 5/0 -> 0xFFFFFFFF with out_valid at T+1; rem 5/0 -> 5.
  - Overflow: div 0x80000000/0xFFFFFFFF -> 0x80000000; rem -> 0.
- Flush at T+10 of a divu: out_valid never asserts, in_ready=1 at T+11. Next divu 9/3 accepted there -> 3 at its T+33.
- Backpressure: out_ready low 5 cycles in DONE -> result/out_valid held constant. out_ready+flush in the same cycle -> IDLE, no handshake counted.
- Reset: resetn low mid-CALC -> next cycle out_valid=0, busy=0, in_ready=1. in_valid with div_op=000 -> no accept, stays IDLE.
